// File: rtl/cell_stim_pkg.sv
// Shared definitions for the NAND4-class cell stimulus sequencer.
//   state_t    : sequencer FSM states
//   MODE_*     : vector ordering selectors
//   *_CNT_W    : widths of the saturating result counters
//   bin2gray() : binary to reflected Gray code mapping
package cell_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned TOG_CNT_W = 16;

  // Widest vector the Gray helper handles; callers zero-extend and truncate.
  localparam int unsigned VEC_MAX_W = 16;

  function automatic logic [VEC_MAX_W-1:0] bin2gray(input logic [VEC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cell_stim_vecgen.sv
// Vector index / pass counter for the cell stimulus sequencer.
//   clk, rstb   : clock, async active-low reset
//   load        : start of run, clears index and captures mode / pass count
//   adv         : step to the next vector
//   mode        : ordering at load (MODE_BIN / MODE_GRAY)
//   repeat_num  : number of passes at load
//   vec_nxt_c   : mapped vector for the index after the current one
//   last_c      : current index is the final vector of the final pass
module cell_stim_vecgen
  import cell_stim_pkg::*;
#(
  parameter int unsigned N_IN     = 4,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                load,
  input  logic                adv,
  input  logic                mode,
  input  logic [REPEAT_W-1:0] repeat_num,
  output logic [N_IN-1:0]     vec_nxt_c,
  output logic                last_c
);

  logic [N_IN-1:0]     idx_q;
  logic [N_IN-1:0]     idx_inc;
  logic [REPEAT_W-1:0] pass_q;
  logic                mode_q;
  logic                wrap_c;

  // Index increment wraps naturally at 2^N_IN-1 -> 0.
  assign idx_inc = idx_q + N_IN'(1);
  assign wrap_c  = &idx_q;
  assign last_c  = wrap_c && (pass_q == REPEAT_W'(1));

  // Map the upcoming index to the applied vector.
  always_comb begin
    vec_nxt_c = idx_inc;
    if (mode_q == MODE_GRAY) begin
      vec_nxt_c = N_IN'(bin2gray(VEC_MAX_W'(idx_inc)));
    end
  end

  // Index, remaining passes and latched ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idx_q  <= '0;
      pass_q <= '0;
      mode_q <= MODE_BIN;
    end else if (load) begin
      idx_q  <= '0;
      pass_q <= repeat_num;
      mode_q <= mode;
    end else if (adv) begin
      idx_q <= idx_inc;
      if (wrap_c) begin
        pass_q <= pass_q - REPEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cell_stim_seq.sv
// Stimulus sequencer and checker for a 4-input NAND-class cell.
// Walks every input vector (binary or Gray order) for REPEAT passes, waits
// SETTLE_CYC cycles per vector, samples the cell output, counts mismatches
// against ~&stim and output toggles between consecutive samples.
//   clk, rstb  : clock, async active-low reset
//   start      : run request (IDLE only, blocked by abort)
//   abort      : terminate run, ends with a done pulse
//   mode       : 0 binary, 1 Gray; captured on start
//   repeat_num : pass count; captured on start
//   qn_in      : cell output (combinational return from stim)
//   stim       : registered cell inputs, bit 0 drives IN1
//   busy       : run in progress
//   done       : one-cycle pulse at end of run
//   err_cnt    : saturating mismatch count
//   tog_cnt    : saturating output toggle count
//   err_vld    : at least one mismatch this run
//   err_vec    : first mismatching vector
module cell_stim_seq
  import cell_stim_pkg::*;
#(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned REPEAT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 mode,
  input  logic [REPEAT_W-1:0]  repeat_num,
  input  logic                 qn_in,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [TOG_CNT_W-1:0] tog_cnt,
  output logic                 err_vld,
  output logic [N_IN-1:0]      err_vec
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t               state_q, state_n;
  logic [SET_W-1:0]     set_cnt_q, set_cnt_n;
  logic                 prev_qn_q, prev_qn_n;
  logic                 first_q, first_n;
  logic [N_IN-1:0]      stim_n;
  logic                 busy_n;
  logic                 done_n;
  logic [ERR_CNT_W-1:0] err_cnt_n;
  logic [TOG_CNT_W-1:0] tog_cnt_n;
  logic                 err_vld_n;
  logic [N_IN-1:0]      err_vec_n;

  logic                 load_c;
  logic                 adv_c;
  logic                 last_c;
  logic [N_IN-1:0]      vec_nxt_c;
  logic                 mismatch_c;
  logic                 toggle_c;

  cell_stim_vecgen #(
    .N_IN     (N_IN),
    .REPEAT_W (REPEAT_W)
  ) u_vecgen (
    .clk        (clk),
    .rstb       (rstb),
    .load       (load_c),
    .adv        (adv_c),
    .mode       (mode),
    .repeat_num (repeat_num),
    .vec_nxt_c  (vec_nxt_c),
    .last_c     (last_c)
  );

  // Good NAND output is 0 only for the all-ones vector.
  assign mismatch_c = (qn_in != (~&stim));
  // The first sample of a run has no predecessor to toggle against.
  assign toggle_c   = !first_q && (qn_in != prev_qn_q);

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    set_cnt_n = set_cnt_q;
    prev_qn_n = prev_qn_q;
    first_n   = first_q;
    stim_n    = stim;
    busy_n    = busy;
    done_n    = 1'b0;
    err_cnt_n = err_cnt;
    tog_cnt_n = tog_cnt;
    err_vld_n = err_vld;
    err_vec_n = err_vec;
    load_c    = 1'b0;
    adv_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stim_n = '0;
        if (start && !abort) begin
          load_c    = 1'b1;
          err_cnt_n = '0;
          tog_cnt_n = '0;
          err_vld_n = 1'b0;
          err_vec_n = '0;
          first_n   = 1'b1;
          set_cnt_n = '0;
          if (repeat_num == '0) begin
            state_n = ST_FIN;
            done_n  = 1'b1;
          end else begin
            // Index 0 maps to all-zeros in both orderings.
            stim_n  = '0;
            busy_n  = 1'b1;
            state_n = ST_SETTLE;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
          stim_n  = '0;
        end else if (set_cnt_q == SET_LAST) begin
          set_cnt_n = '0;
          state_n   = ST_SAMPLE;
        end else begin
          set_cnt_n = set_cnt_q + SET_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_n = ST_FIN;
          done_n  = 1'b1;
          stim_n  = '0;
        end else begin
          if (mismatch_c) begin
            if (err_cnt != '1) begin
              err_cnt_n = err_cnt + ERR_CNT_W'(1);
            end
            if (!err_vld) begin
              err_vld_n = 1'b1;
              err_vec_n = stim;
            end
          end
          if (toggle_c && (tog_cnt != '1)) begin
            tog_cnt_n = tog_cnt + TOG_CNT_W'(1);
          end
          prev_qn_n = qn_in;
          first_n   = 1'b0;
          if (last_c) begin
            state_n = ST_FIN;
            done_n  = 1'b1;
            stim_n  = '0;
          end else begin
            adv_c     = 1'b1;
            stim_n    = vec_nxt_c;
            set_cnt_n = '0;
            state_n   = ST_SETTLE;
          end
        end
      end

      ST_FIN: begin
        busy_n  = 1'b0;
        stim_n  = '0;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        stim_n  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      set_cnt_q <= '0;
      prev_qn_q <= 1'b0;
      first_q   <= 1'b1;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      tog_cnt   <= '0;
      err_vld   <= 1'b0;
      err_vec   <= '0;
    end else begin
      state_q   <= state_n;
      set_cnt_q <= set_cnt_n;
      prev_qn_q <= prev_qn_n;
      first_q   <= first_n;
      stim      <= stim_n;
      busy      <= busy_n;
      done      <= done_n;
      err_cnt   <= err_cnt_n;
      tog_cnt   <= tog_cnt_n;
      err_vld   <= err_vld_n;
      err_vec   <= err_vec_n;
    end
  end

endmodule

// File: tb/tb_cell_stim_seq.sv
// Scoreboard bench for cell_stim_seq: each run pushes its expected end-of-run
// result; a monitor pops and compares on every done pulse.
module tb_cell_stim_seq;

  localparam int unsigned N_IN       = 4;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned REPEAT_W   = 8;
  localparam int          PER        = 16 * (SETTLE_CYC + 1);

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                mode = 1'b0;
  logic [REPEAT_W-1:0] repeat_num = '0;
  logic                qn_in;
  logic [N_IN-1:0]     stim;
  logic                busy;
  logic                done;
  logic [7:0]          err_cnt;
  logic [15:0]         tog_cnt;
  logic                err_vld;
  logic [N_IN-1:0]     err_vec;

  // Cell model: 0 good NAND4, 1 stuck-at-1, 2 stuck-at-0.
  int fault = 0;
  assign qn_in = (fault == 1) ? 1'b1 : (fault == 2) ? 1'b0 : ~&stim;

  cell_stim_seq #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC),
    .REPEAT_W   (REPEAT_W)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .repeat_num (repeat_num),
    .qn_in      (qn_in),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .tog_cnt    (tog_cnt),
    .err_vld    (err_vld),
    .err_vec    (err_vec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  typedef struct {
    int          done_cyc;
    logic [7:0]  err;
    logic [15:0] tog;
    logic        vld;
    logic [3:0]  vec;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
        chk("err_cnt", 32'(err_cnt), 32'(e.err));
        chk("tog_cnt", 32'(tog_cnt), 32'(e.tog));
        chk("err_vld", 32'(err_vld), 32'(e.vld));
        chk("err_vec", 32'(err_vec), 32'(e.vec));
        chk("busy_in_done", 32'(busy), 32'(e.busy));
      end
    end
  end

  // Issue a run; the accept edge is the posedge after start is raised.
  task automatic launch(input logic m, input logic [7:0] r, input int f, input bit push,
                        input int lat, input logic [7:0] e_err, input logic [15:0] e_tog,
                        input logic e_vld, input logic [3:0] e_vec, input logic e_busy);
    exp_t e;
    @(posedge clk); #1;
    fault      = f;
    mode       = m;
    repeat_num = r;
    start      = 1'b1;
    if (push) begin
      e.done_cyc = cyc + 1 + lat;
      e.err      = e_err;
      e.tog      = e_tog;
      e.vld      = e_vld;
      e.vec      = e_vec;
      e.busy     = e_busy;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (done_seen != prev) return;
    end
    chk("done_timeout", 32'(done_seen), 32'(prev + 1));
    sb.delete();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk); #2;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_stim"}, 32'(stim), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_stim"}, 32'(stim), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_tog_cnt"}, 32'(tog_cnt), 32'd0);
    chk({tag, "_err_vld"}, 32'(err_vld), 32'd0);
    chk({tag, "_err_vec"}, 32'(err_vec), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    #1;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;

    // Gray, 3 passes, good cell: one low output per pass -> 2 toggles per pass.
    d0 = done_seen;
    launch(1'b1, 8'd3, 0, 1'b1, 3 * PER, 8'd0, 16'd6, 1'b0, 4'h0, 1'b1);
    wait_done(d0, 3 * PER + 40);
    check_idle("gray3_after");

    // Binary, 2 passes, good cell: toggles at idx15, idx0 (pass 2), idx15.
    d0 = done_seen;
    launch(1'b0, 8'd2, 0, 1'b1, 2 * PER, 8'd0, 16'd3, 1'b0, 4'h0, 1'b1);
    wait_done(d0, 2 * PER + 40);
    check_idle("bin2_after");

    // Stuck-at-1: only the all-ones vector mismatches.
    d0 = done_seen;
    launch(1'b0, 8'd1, 1, 1'b1, PER, 8'd1, 16'd0, 1'b1, 4'hF, 1'b1);
    wait_done(d0, PER + 40);

    // Stuck-at-0 over 20 passes: 300 mismatches saturate at 255.
    d0 = done_seen;
    launch(1'b0, 8'd20, 2, 1'b1, 20 * PER, 8'd255, 16'd0, 1'b1, 4'h0, 1'b1);
    wait_done(d0, 20 * PER + 40);

    // Zero passes: done right after start, counters cleared, never busy.
    d0 = done_seen;
    launch(1'b0, 8'd0, 0, 1'b1, 0, 8'd0, 16'd0, 1'b0, 4'h0, 1'b0);
    wait_done(d0, 10);
    check_idle("rpt0_after");

    // Abort in run cycle 10: samples of idx 0..2 taken (stuck-at-0 -> 3 errors);
    // a start issued mid-run must be ignored.
    d0 = done_seen;
    launch(1'b0, 8'd1, 2, 1'b1, 10, 8'd3, 16'd0, 1'b1, 4'h0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start      = 1'b1;
    repeat_num = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(d0, 20);
    check_idle("abort_after");

    // Start together with abort in IDLE is not accepted.
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    repeat_num = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_no_done", 32'(done_seen), 32'(d0));

    // Reset mid-run: outputs drop at once and no done pulse follows.
    d0 = done_seen;
    launch(1'b1, 8'd2, 2, 1'b0, 0, 8'd0, 16'd0, 1'b0, 4'h0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_no_done", 32'(done_seen), 32'(d0));

    // Normal run after reset: Gray, 1 pass, good cell.
    d0 = done_seen;
    launch(1'b1, 8'd1, 0, 1'b1, PER, 8'd0, 16'd2, 1'b0, 4'h0, 1'b1);
    wait_done(d0, PER + 40);
    check_idle("post_reset_after");

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_stim_seq.md
# cell_stim_seq

Stimulus sequencer and checker for a 4-input combinational cell under test (NAND4-class gate). It drives every input vector onto the cell in binary or Gray order, waits a programmable settle time, samples the cell output and compares it against the expected NAND result. It also counts output toggles for power-characterisation runs. It sits between the test-power harness control logic and the cell instance, and owns the cell's inputs exclusively while busy.

## Interface
- `N_IN`, 4, number of cell inputs; one pass is 2^N_IN vectors.
- `SETTLE_CYC`, 2, cycles (≥1) between vector application and output sampling.
- `REPEAT_W`, 8, width of the pass-count input.
- `CLK` in 1: sole clock, rising edge.
- `RSTB` in 1: reset, asynchronous, active-low.
- `START` in 1: run request; accepted only in IDLE.
- `ABORT` in 1: terminate run.
- `MODE` in 1: vector order, 0 = binary count, 1 = Gray code. Captured on START.
- `REPEAT` in `REPEAT_W`: number of passes. Captured on START.
- `QN_IN` in 1: cell output.
- `STIM` out `N_IN`: registered cell inputs; bit 0 drives IN1.
- `BUSY` out 1: run in progress.
- `DONE` out 1: one-cycle pulse at end of run, whether completed or aborted.
- `ERR_CNT` out 8: mismatch count, saturating at 255.
- `TOG_CNT` out 16: count of QN_IN changes between consecutive samples, saturating.
- `ERR_VLD` out 1: at least one mismatch seen this run.
- `ERR_VEC` out `N_IN`: first mismatching vector.

## Operation
- Reset values: `STIM`=0, `BUSY`=0, `DONE`=0, `ERR_CNT`=0, `TOG_CNT`=0, `ERR_VLD`=0, `ERR_VEC`=0. FSM starts in IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, FIN.
- **IDLE**
  - `STIM` holds 0.
  - When `START`=1 and `ABORT`=0:
    - Clear all counters, `ERR_VLD` and `ERR_VEC`.
    - Latch `MODE` and `REPEAT`.
    - If `REPEAT`=0, go to FIN.
    - Otherwise load vector index 0 onto `STIM`, set `BUSY`, go to SETTLE.
- **SETTLE**
  - Count `SETTLE_CYC` cycles.
  - On the last count, go to SAMPLE.
- **SAMPLE**
  - Compare `QN_IN` with the expected value ~&`STIM`.
  - On mismatch, increment `ERR_CNT` (saturating). On the first mismatch of the run, set `ERR_VLD` and capture `STIM` into `ERR_VEC`.
  - If this is not the first sample of the run and `QN_IN` differs from the previous sample, increment `TOG_CNT`. The previous sample is carried across pass boundaries.
  - Then advance:
    - If more vectors remain, advance the index (wrapping 2^N_IN−1 → 0 and decrementing the pass count on wrap), update `STIM`, go to SETTLE.
    - Otherwise go to FIN.
- **FIN**
  - Pulse `DONE` for one cycle, clear `BUSY`, drive `STIM` to 0, return to IDLE.
  - Counters hold until the next accepted START.
- **Vector order:** `STIM` = index in binary mode, or index ^ (index>>1) in Gray mode.
- **ABORT**
  - In SETTLE or SAMPLE, takes priority over everything: the current sample is discarded, next state is FIN.
  - In IDLE, ABORT blocks START.
- **Restrictions:** START while `BUSY` is ignored. `MODE` and `REPEAT` changes mid-run have no effect.
- **Reset mid-run:** RSTB low asynchronously forces all reset values. No `DONE` pulse is generated.

## Timing
- `STIM` changes on the clock edge entering SETTLE.
- `QN_IN` is sampled SETTLE_CYC+1 edges after each `STIM` change. Per-vector period is SETTLE_CYC+1 cycles.
- START accepted at edge t → first `STIM` valid at t.
- Last SAMPLE at edge t+REPEAT·2^N_IN·(SETTLE_CYC+1)−1. `DONE` high for the following cycle, `BUSY` low after it.
- `REPEAT`=0: `DONE` high in the cycle after the START edge, `BUSY` never asserts.
- Counter updates from a SAMPLE are visible the cycle after that SAMPLE.
- `QN_IN` is a combinational return path from `STIM`; no synchroniser. `SETTLE_CYC` covers the cell delay.

## Structure
- Package `cell_stim_pkg` holds:
  - State enum (IDLE/SETTLE/SAMPLE/FIN).
  - MODE constants BIN=0, GRAY=1.
  - Binary-to-Gray function.
  - Counter saturation widths.
- Sub-module `cell_stim_vecgen` holds the index counter, pass counter, wrap/last flags and binary/Gray mapping.
- The FSM, compare, toggle and error logic stay in the top module.

## Test plan
- Good NAND4 model, MODE=1, REPEAT=3, SETTLE_CYC=2 → `DONE` 144 cycles after START; `TOG_CNT`=6, `ERR_CNT`=0, `ERR_VLD`=0.
- Good model, MODE=0, REPEAT=2 → `TOG_CNT`=3 (idx15 pass1, idx0 pass2, idx15 pass2), `ERR_CNT`=0, `STIM`=0 after `DONE`.
- Stuck-at-1 `QN_IN`, MODE=0, REPEAT=1 → `ERR_CNT`=1, `ERR_VEC`=4'hF, `TOG_CNT`=0.
- Stuck-at-0 `QN_IN`, REPEAT=20, MODE=0 → `ERR_CNT` saturates at 255 (not 300), `ERR_VEC`=4'h0.
- ABORT asserted in the 10th cycle of a run → `DONE` next cycle, then `BUSY`=0; a START during the run was ignored; a START in the same cycle as ABORT in IDLE is not accepted.
- RSTB pulsed low mid-run → all outputs return to reset values immediately; no `DONE`; a new START runs normally.
